sequenciador_programa: RTL and testbench

- Program sequencer for the multicycle processor (8x16-bit registers, A/G, add/sub ALU; instruction format IIIXXXYYY, opcodes mv=000, mvi=001, add=010, sub=011).
- Holds a small program memory and feeds one instruction at a time to the processor through DIN/Run, then waits for Done.
- Presents the immediate word for mvi and advances its PC.
- Stops on a halt word, at end of memory, or on a Done timeout. Sits between the board/testbench and the processor's DIN, Run and Done pins.

---
 rtl/sequenciador_programa_pkg.sv | 31 +++
 rtl/sequenciador_programa_memoria.sv | 32 +++
 rtl/sequenciador_programa.sv | 146 ++++++++++++++
 tb/tb_sequenciador_programa.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_programa_pkg.sv
// Shared opcodes, sequencer state encoding and instruction field helpers.
// Instruction format IIIXXXYYY: opcode [8:6], destination X [5:3], source Y [2:0].
package sequenciador_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    BUSCA  = 3'd1,
    ESPERA = 3'd2,
    PARADO = 3'd3,
    ERRO   = 3'd4
  } estado_t;

  function automatic logic [2:0] campo_op(input logic [15:0] palavra);
    return palavra[8:6];
  endfunction

  function automatic logic [2:0] campo_x(input logic [15:0] palavra);
    return palavra[5:3];
  endfunction

  function automatic logic [2:0] campo_y(input logic [15:0] palavra);
    return palavra[2:0];
  endfunction

endpackage

// File: rtl/sequenciador_programa_memoria.sv
// Program memory: one synchronous write port, two combinational read ports (Pc and Pc+1).
// Zero-latency reads, writes land on the next rising edge; no backpressure.
module memoria_programa
  import sequenciador_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          core_clk,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_dat,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [15:0]   rd_dat_a,
  output logic [15:0]   rd_dat_b
);

  localparam int DEPTH = 2 ** AW;

  // Contents deliberately survive reset so a program can be re-run after Resetn.
  logic [15:0] mem [DEPTH];

  always_ff @(posedge core_clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat_a = mem[rd_addr_a];
  assign rd_dat_b = mem[rd_addr_b];

endmodule

// File: rtl/sequenciador_programa.sv
// Program sequencer: issues one instruction per Run strobe to the processor and waits for Done.
// Run is a one-cycle strobe in BUSCA; ESPERA holds until Done or the timeout expires.
module sequenciador_programa
  import sequenciador_pkg::*;
#(
  parameter int         AW      = 4,
  parameter int         TIMEOUT = 8,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Prog_we,
  input  logic [AW-1:0] Prog_addr,
  input  logic [15:0]   Prog_data,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] Pc,
  output logic          Busy,
  output logic          Halted,
  output logic          Erro
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] PC_MAX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   FIM_MEM = (AW + 1)'(DEPTH - 1);
  localparam logic [7:0]    CNT_MAX = 8'(TIMEOUT - 1);

  estado_t       estado, estado_prox;
  logic [AW-1:0] pc_q, pc_prox;
  logic [7:0]    cnt_q, cnt_prox;

  logic [AW-1:0] pc_seg;
  logic [15:0]   palavra, palavra_seg;
  logic [2:0]    op_atual;
  logic          eh_mvi, eh_halt, mvi_sem_imediato;
  logic [AW:0]   passo, pc_soma;
  logic          passa_fim;
  logic          wr_vld;

  assign pc_seg = pc_q + 1'b1;

  // Writes are only safe while no program is being fed to the processor.
  assign wr_vld = Prog_we && (estado != BUSCA) && (estado != ESPERA);

  memoria_programa #(.AW(AW)) u_mem (
    .core_clk  (Clock),
    .wr_vld    (wr_vld),
    .wr_addr   (Prog_addr),
    .wr_dat    (Prog_data),
    .rd_addr_a (pc_q),
    .rd_addr_b (pc_seg),
    .rd_dat_a  (palavra),
    .rd_dat_b  (palavra_seg)
  );

  assign op_atual         = campo_op(palavra);
  assign eh_mvi           = (op_atual == OP_MVI);
  assign eh_halt          = (op_atual == HALT_OP);
  assign mvi_sem_imediato = eh_mvi && (pc_q == PC_MAX);

  // End of memory is checked one bit wider so Pc never wraps.
  assign passo     = eh_mvi ? (AW + 1)'(2) : (AW + 1)'(1);
  assign pc_soma   = {1'b0, pc_q} + passo;
  assign passa_fim = (pc_soma > FIM_MEM);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado <= OCIOSO;
      pc_q   <= '0;
      cnt_q  <= '0;
    end else begin
      estado <= estado_prox;
      pc_q   <= pc_prox;
      cnt_q  <= cnt_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    pc_prox     = pc_q;
    cnt_prox    = cnt_q;
    case (estado)
      OCIOSO, PARADO, ERRO: begin
        if (Start) begin
          pc_prox     = '0;
          cnt_prox    = '0;
          estado_prox = BUSCA;
        end
      end
      BUSCA: begin
        if (eh_halt) begin
          estado_prox = PARADO;
        end else if (mvi_sem_imediato) begin
          estado_prox = ERRO;
        end else begin
          cnt_prox    = '0;
          estado_prox = ESPERA;
        end
      end
      ESPERA: begin
        if (Done) begin
          if (passa_fim) begin
            estado_prox = PARADO;
          end else begin
            pc_prox     = pc_soma[AW-1:0];
            estado_prox = BUSCA;
          end
        end else if (cnt_q == CNT_MAX) begin
          estado_prox = ERRO;
        end else begin
          cnt_prox = cnt_q + 8'd1;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Moore decodes; in ESPERA of an mvi the processor reads the immediate word.
  always_comb begin
    Run    = 1'b0;
    Busy   = 1'b0;
    Halted = 1'b0;
    Erro   = 1'b0;
    DIN    = palavra;
    case (estado)
      BUSCA: begin
        Busy = 1'b1;
        Run  = !eh_halt && !mvi_sem_imediato;
      end
      ESPERA: begin
        Busy = 1'b1;
        if (eh_mvi) begin
          DIN = palavra_seg;
        end
      end
      PARADO:  Halted = 1'b1;
      ERRO:    Erro   = 1'b1;
      default: ;
    endcase
  end

  assign Pc = pc_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Scoreboard bench: a program-level reference model queues expected issues; a monitor checks each Run.
// A small behavioural processor answers Run with Done after 2 (mv/mvi) or 4 (add/sub) cycles.
module tb_sequenciador_programa;
  import sequenciador_pkg::*;

  localparam int AW      = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic          Start;
  logic          Prog_we;
  logic [AW-1:0] Prog_addr;
  logic [15:0]   Prog_data;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic [AW-1:0] Pc;
  logic          Busy;
  logic          Halted;
  logic          Erro;

  always #5 Clock = ~Clock;

  sequenciador_programa #(.AW(AW), .TIMEOUT(TIMEOUT), .HALT_OP(OP_HALT)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Prog_we   (Prog_we),
    .Prog_addr (Prog_addr),
    .Prog_data (Prog_data),
    .Done      (Done),
    .DIN       (DIN),
    .Run       (Run),
    .Pc        (Pc),
    .Busy      (Busy),
    .Halted    (Halted),
    .Erro      (Erro)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  // ---------------- behavioural processor ----------------
  logic [15:0] r [8];
  logic [15:0] ir, acc_a, acc_g;
  int          t;
  logic        done_en;

  assign Done = done_en && (t != 0) &&
                ((t == 1 && (ir[8:6] == OP_MV || ir[8:6] == OP_MVI)) ||
                 (t == 3 && (ir[8:6] == OP_ADD || ir[8:6] == OP_SUB)));

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) r[i] <= '0;
      ir <= '0; acc_a <= '0; acc_g <= '0; t <= 0;
    end else if (Run) begin
      ir <= DIN;
      t  <= 1;
    end else if (t != 0) begin
      if (Done) begin
        t <= 0;
        case (ir[8:6])
          OP_MV:   r[ir[5:3]] <= r[ir[2:0]];
          OP_MVI:  r[ir[5:3]] <= DIN;
          default: r[ir[5:3]] <= acc_g;
        endcase
      end else if (t == 1 && (ir[8:6] == OP_ADD || ir[8:6] == OP_SUB)) begin
        acc_a <= r[ir[5:3]];
        t <= 2;
      end else if (t == 2) begin
        acc_g <= (ir[8:6] == OP_SUB) ? acc_a - r[ir[2:0]] : acc_a + r[ir[2:0]];
        t <= 3;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] sh [DEPTH];
  logic [15:0] ref_r [8];
  logic [15:0] q_din [$];
  logic [15:0] q_imm [$];
  bit          exp_halt, exp_erro;
  int          exp_pc, exp_esp;

  task automatic modelo(input bit proc_on);
    int pc = 0;
    logic [15:0] w;
    logic [2:0] op;
    exp_halt = 0; exp_erro = 0; exp_esp = -1;
    for (int k = 0; k < 40; k++) begin
      w  = sh[pc];
      op = w[8:6];
      if (op == OP_HALT) begin exp_halt = 1; break; end
      if (op == OP_MVI && pc == DEPTH - 1) begin exp_erro = 1; break; end
      q_din.push_back(w);
      if (op == OP_MVI) q_imm.push_back(sh[pc + 1]);
      if (!proc_on) begin exp_erro = 1; exp_esp = TIMEOUT; break; end
      case (op)
        OP_MV:   ref_r[w[5:3]] = ref_r[w[2:0]];
        OP_MVI:  ref_r[w[5:3]] = sh[pc + 1];
        OP_ADD:  ref_r[w[5:3]] = ref_r[w[5:3]] + ref_r[w[2:0]];
        default: ref_r[w[5:3]] = ref_r[w[5:3]] - ref_r[w[2:0]];
      endcase
      if (pc + ((op == OP_MVI) ? 2 : 1) > DEPTH - 1) begin exp_halt = 1; break; end
      pc += (op == OP_MVI) ? 2 : 1;
    end
    exp_pc = pc;
  endtask

  // ---------------- monitor ----------------
  bit          prev_run = 0;
  bit          want_imm = 0;
  logic [15:0] imm_exp, mon_w;
  int          esp_cnt  = 0;

  always @(negedge Clock) begin
    if (want_imm) begin
      chk("imm_din", DIN, imm_exp);
      want_imm = 0;
    end
    if (Run) begin
      chk("run_not_b2b", prev_run, 1'b0);
      if (q_din.size() == 0) begin
        chk("unexpected_run", DIN, 16'hxxxx);
      end else begin
        mon_w = q_din.pop_front();
        chk("run_din", DIN, mon_w);
        if (mon_w[8:6] == OP_MVI && q_imm.size() != 0) begin
          imm_exp  = q_imm.pop_front();
          want_imm = 1;
        end
      end
      esp_cnt = 0;
    end else if (Busy) begin
      esp_cnt++;
    end
    prev_run = Run;
  end

  // ---------------- stimulus helpers ----------------
  task automatic limpa_modelo();
    q_din.delete();
    q_imm.delete();
    want_imm = 0;
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
  endtask

  task automatic aplica_reset();
    @(negedge Clock);
    Resetn = 0;
    limpa_modelo();
    @(negedge Clock);
    Resetn = 1;
  endtask

  task automatic programa_tudo();
    @(negedge Clock);
    Prog_we = 1;
    for (int i = 0; i < DEPTH; i++) begin
      Prog_addr = AW'(i);
      Prog_data = sh[i];
      @(negedge Clock);
    end
    Prog_we = 0;
  endtask

  // perturb: mid-run write to [0] and a second Start, both to be ignored.
  // wr0: write sh[0] in the same cycle as Start.
  task automatic executa(input bit proc_on, input bit perturb, input bit wr0);
    done_en = proc_on;
    modelo(proc_on);
    @(negedge Clock);
    Start = 1;
    if (wr0) begin
      Prog_we = 1; Prog_addr = '0; Prog_data = sh[0];
    end
    @(negedge Clock);
    Start = 0; Prog_we = 0;
    for (int c = 0; c < 1000 && Busy; c++) begin
      @(negedge Clock);
      Prog_we   = perturb && (c == 2);
      Start     = perturb && (c == 4);
      Prog_addr = '0;
      Prog_data = 16'h01C0;
    end
    Prog_we = 0; Start = 0;
    chk("busy_end", Busy, 1'b0);
    chk("runs_pending", q_din.size(), 0);
    chk("halted", Halted, exp_halt);
    chk("erro", Erro, exp_erro);
    chk("pc_final", Pc, exp_pc);
    chk("run_idle", Run, 1'b0);
    if (exp_esp >= 0) chk("timeout_cycles", esp_cnt, exp_esp);
    if (proc_on) for (int i = 0; i < 8; i++) chk("reg", r[i], ref_r[i]);
  endtask

  function automatic logic [15:0] palavra_aleatoria();
    logic [15:0] w;
    int s;
    w = 16'($urandom);
    s = $urandom_range(0, 9);
    if (s < 2)      w[8:6] = OP_MV;
    else if (s < 5) w[8:6] = OP_MVI;
    else if (s < 7) w[8:6] = OP_ADD;
    else if (s < 9) w[8:6] = OP_SUB;
    else            w[8:6] = OP_HALT;
    return w;
  endfunction

  task automatic programa_exemplo();
    for (int i = 0; i < DEPTH; i++) sh[i] = 16'h0000;
    sh[0] = 16'h0040; sh[1] = 16'h0005; sh[2] = 16'h0048;
    sh[3] = 16'h0003; sh[4] = 16'h0081; sh[5] = 16'h01C0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit achou;
    Resetn = 0; Start = 0; Prog_we = 0; Prog_addr = '0; Prog_data = '0; done_en = 1;
    limpa_modelo();
    repeat (2) @(negedge Clock);
    chk("rst_run", Run, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_erro", Erro, 1'b0);
    chk("rst_pc", Pc, 0);
    Resetn = 1;

    // Example program: mvi R0,5; mvi R1,3; add R0,R1; halt
    programa_exemplo();
    programa_tudo();
    executa(1, 0, 0);
    chk("ex_r0", r[0], 16'h0008);
    chk("ex_pc", Pc, 5);

    // Done never arrives
    sh[0] = 16'h0081;
    programa_tudo();
    executa(0, 0, 0);
    chk("to_pc", Pc, 0);
    done_en = 1;
    aplica_reset();

    // mvi in the last word has no immediate
    for (int i = 0; i < DEPTH - 1; i++) sh[i] = 16'h0000;
    sh[DEPTH-1] = 16'h0040;
    programa_tudo();
    executa(1, 0, 0);

    // Sixteen mv with no halt: stop at the end without wrapping
    sh[DEPTH-1] = 16'h0000;
    programa_tudo();
    executa(1, 0, 0);
    chk("nowrap_pc", Pc, DEPTH - 1);

    // Write and Start while busy are both ignored; rerun issues the original word
    programa_exemplo();
    programa_tudo();
    executa(1, 1, 0);
    executa(1, 0, 0);

    // Asynchronous reset in the middle of an add
    modelo(1);
    @(negedge Clock);
    Start = 1;
    @(negedge Clock);
    Start = 0;
    achou = 0;
    for (int c = 0; c < 100; c++) begin
      if (Run && DIN[8:6] == OP_ADD) begin achou = 1; break; end
      @(negedge Clock);
    end
    chk("add_issued", achou, 1'b1);
    @(negedge Clock);
    #1 Resetn = 0;
    #1;
    chk("arst_run", Run, 1'b0);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_pc", Pc, 0);
    chk("arst_din", DIN, sh[0]);
    limpa_modelo();
    @(negedge Clock);
    Resetn = 1;
    executa(1, 0, 0);

    // Randomized programs, sometimes rewriting [0] in the Start cycle
    for (int n = 0; n < 30; n++) begin
      bit wr0;
      for (int i = 0; i < DEPTH; i++) sh[i] = palavra_aleatoria();
      programa_tudo();
      wr0 = ($urandom_range(0, 3) == 0);
      if (wr0) sh[0] = palavra_aleatoria();
      executa(1, 0, wr0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
